// File: rtl/dm_bus_arbiter.sv
// rtl/dm_bus_arbiter.sv - round-robin arbiter of N requesters onto the DM system-bus master port
// Optional grant lock across transactions when DM_ARB_LOCK_EN is defined.
module dm_bus_arbiter #(
    parameter int NrPorts        = 2,
    parameter int BusWidth       = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NrPorts-1:0]                    req_i,
    input  logic [NrPorts-1:0][BusWidth-1:0]      add_i,
    input  logic [NrPorts-1:0]                    we_i,
    input  logic [NrPorts-1:0][BusWidth-1:0]      wdata_i,
    input  logic [NrPorts-1:0][BusWidth/8-1:0]    be_i,
    input  logic [NrPorts-1:0]                    lock_i,
    output logic [NrPorts-1:0]                    gnt_o,
    output logic [NrPorts-1:0]                    r_valid_o,
    output logic [BusWidth-1:0]                   r_rdata_o,
    output logic                                  master_req_o,
    output logic [BusWidth-1:0]                   master_add_o,
    output logic                                  master_we_o,
    output logic [BusWidth-1:0]                   master_wdata_o,
    output logic [BusWidth/8-1:0]                 master_be_o,
    input  logic                                  master_gnt_i,
    input  logic                                  master_r_valid_i,
    input  logic [BusWidth-1:0]                   master_r_rdata_i,
    output logic                                  err_o
);

    localparam int IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    if (!(BusWidth == 32 || BusWidth == 64)) begin : g_bad_width
        $error("dm_bus_arbiter: BusWidth must be 32 or 64");
    end
    if (NrPorts < 2) begin : g_bad_ports
        $error("dm_bus_arbiter: NrPorts must be >= 2");
    end
    if (MaxOutstanding < 1 || (MaxOutstanding & (MaxOutstanding - 1)) != 0) begin : g_bad_depth
        $error("dm_bus_arbiter: MaxOutstanding must be a power of 2");
    end

    logic [IdxW-1:0] rr_q, rr_d, held_q, held_d, sel, sel_scan;
    logic            hold_q, hold_d;
    logic [MaxOutstanding-1:0][IdxW-1:0] ids_q, ids_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full, issue, handshake, pop;

`ifdef DM_ARB_LOCK_EN
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_active;
    assign lock_active = lock_q && lock_i[lock_idx_q];
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;
`endif

    always_comb begin
        int  idx;
        logic found;
        sel_scan = rr_q;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NrPorts; k++) begin
            idx = (int'(rr_q) + k) % NrPorts;
            if (!found && req_i[idx]) begin
                sel_scan = IdxW'(idx);
                found    = 1'b1;
            end
        end
        sel = hold_q ? held_q : sel_scan;
`ifdef DM_ARB_LOCK_EN
        if (lock_active) sel = lock_idx_q;
`endif
    end

    // A pop in the same cycle does not relieve a full FIFO; only the registered count matters.
    assign full      = (count_q == CntW'(MaxOutstanding));
    assign issue     = req_i[sel] && !full;
    assign handshake = issue && master_gnt_i;
    assign pop       = master_r_valid_i && (count_q != '0);

    assign master_req_o   = issue;
    assign master_add_o   = issue ? add_i[sel]   : '0;
    assign master_we_o    = issue ? we_i[sel]    : 1'b0;
    assign master_wdata_o = issue ? wdata_i[sel] : '0;
    assign master_be_o    = issue ? be_i[sel]    : '0;
    assign r_rdata_o      = master_r_rdata_i;
    assign err_o          = master_r_valid_i && (count_q == '0);

    always_comb begin
        gnt_o      = '0;
        gnt_o[sel] = handshake;
        r_valid_o  = '0;
        if (pop) r_valid_o[ids_q[rd_ptr_q]] = 1'b1;
    end

    always_comb begin
        rr_d     = rr_q;
        hold_d   = hold_q;
        held_d   = held_q;
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (handshake) begin
            rr_d            = (sel == IdxW'(NrPorts - 1)) ? '0 : sel + 1'b1;
            hold_d          = 1'b0;
            ids_d[wr_ptr_q] = sel;
            wr_ptr_d        = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
`ifdef DM_ARB_LOCK_EN
            if (lock_i[sel]) rr_d = sel;
`endif
        end else if (issue) begin
            hold_d = 1'b1;
            held_d = sel;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (handshake && !pop)      count_d = count_q + 1'b1;
        else if (!handshake && pop) count_d = count_q - 1'b1;
    end

`ifdef DM_ARB_LOCK_EN
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (handshake && lock_i[sel]) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end else if (lock_q && !lock_i[lock_idx_q]) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            hold_q   <= 1'b0;
            held_q   <= '0;
            ids_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            hold_q   <= hold_d;
            held_q   <= held_d;
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb/tb_dm_bus_arbiter.sv - directed self-checking bench for dm_bus_arbiter
module tb_dm_bus_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_i;
    logic [1:0][31:0] add_i;
    logic [1:0]       we_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0][3:0]  be_i;
    logic [1:0]       lock_i;
    logic [1:0]       gnt_o;
    logic [1:0]       r_valid_o;
    logic [31:0]      r_rdata_o;
    logic             master_req_o;
    logic [31:0]      master_add_o;
    logic             master_we_o;
    logic [31:0]      master_wdata_o;
    logic [3:0]       master_be_o;
    logic             master_gnt_i;
    logic             master_r_valid_i;
    logic [31:0]      master_r_rdata_i;
    logic             err_o;

    int checks;
    int failures;

    dm_bus_arbiter #(.NrPorts(2), .BusWidth(32), .MaxOutstanding(2)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req_i),
        .add_i            (add_i),
        .we_i             (we_i),
        .wdata_i          (wdata_i),
        .be_i             (be_i),
        .lock_i           (lock_i),
        .gnt_o            (gnt_o),
        .r_valid_o        (r_valid_o),
        .r_rdata_o        (r_rdata_o),
        .master_req_o     (master_req_o),
        .master_add_o     (master_add_o),
        .master_we_o      (master_we_o),
        .master_wdata_o   (master_wdata_o),
        .master_be_o      (master_be_o),
        .master_gnt_i     (master_gnt_i),
        .master_r_valid_i (master_r_valid_i),
        .master_r_rdata_i (master_r_rdata_i),
        .err_o            (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = '0; add_i = '0; we_i = '0; wdata_i = '0; be_i = '0;
        lock_i = '0; master_gnt_i = 1'b0; master_r_valid_i = 1'b0; master_r_rdata_i = '0;
        #3;
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
        checks++; if (r_valid_o !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", r_valid_o); end
        checks++; if (master_req_o !== 1'b0) begin failures++; $display("FAIL reset_mreq got=%b exp=0", master_req_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if (master_add_o !== 32'h0) begin failures++; $display("FAIL reset_add got=%h exp=0", master_add_o); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rv;
        logic [31:0] exp_add;
        add_i[0] = 32'h100; add_i[1] = 32'h200;
        req_i = 2'b11; master_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            master_r_valid_i = (k > 0);
            master_r_rdata_i = (k % 2 == 1) ? 32'hA0 : 32'hB1;
            exp_rv  = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            exp_add = (k % 2 == 0) ? 32'h100 : 32'h200;
            #2;
            checks++; if (gnt_o !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rr_gnt k=%0d got=%b", k, gnt_o); end
            checks++; if (r_valid_o !== exp_rv) begin failures++; $display("FAIL rr_rvalid k=%0d got=%b exp=%b", k, r_valid_o, exp_rv); end
            checks++; if (master_add_o !== exp_add) begin failures++; $display("FAIL rr_add k=%0d got=%h exp=%h", k, master_add_o, exp_add); end
            if (k > 0) begin
                checks++; if (r_rdata_o !== ((k % 2 == 1) ? 32'hA0 : 32'hB1)) begin failures++; $display("FAIL rr_rdata k=%0d got=%h", k, r_rdata_o); end
            end
            cyc();
        end
        req_i = 2'b00; master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'hB1;
        #2;
        checks++; if (r_valid_o !== 2'b10) begin failures++; $display("FAIL rr_drain got=%b exp=10", r_valid_o); end
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL rr_drain_gnt got=%b exp=00", gnt_o); end
        cyc();
        master_r_valid_i = 1'b0;
    endtask

    task automatic test_hold();
        add_i[0] = 32'h2000; add_i[1] = 32'h1000;
        for (int c = 0; c < 4; c++) begin
            req_i = (c == 0) ? 2'b10 : 2'b11;
            master_gnt_i = (c == 3);
            #2;
            checks++; if (master_add_o !== 32'h1000) begin failures++; $display("FAIL hold_add c=%0d got=%h exp=1000", c, master_add_o); end
            checks++; if (gnt_o !== ((c == 3) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL hold_gnt c=%0d got=%b", c, gnt_o); end
            cyc();
        end
        #2;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL hold_next_gnt got=%b exp=01", gnt_o); end
        checks++; if (master_add_o !== 32'h2000) begin failures++; $display("FAIL hold_next_add got=%h exp=2000", master_add_o); end
        cyc();
        req_i = 2'b00; master_gnt_i = 1'b0; master_r_valid_i = 1'b1;
        #2;
        checks++; if (r_valid_o !== 2'b10) begin failures++; $display("FAIL hold_rv0 got=%b exp=10", r_valid_o); end
        cyc();
        #2;
        checks++; if (r_valid_o !== 2'b01) begin failures++; $display("FAIL hold_rv1 got=%b exp=01", r_valid_o); end
        cyc();
        master_r_valid_i = 1'b0;
    endtask

    task automatic test_full();
        logic [1:0] gexp [0:5];
        logic       mexp [0:5];
        gexp = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        mexp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        req_i = 2'b11; master_gnt_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            master_r_valid_i = (c == 4);
            #2;
            checks++; if (gnt_o !== gexp[c]) begin failures++; $display("FAIL full_gnt c=%0d got=%b exp=%b", c, gnt_o, gexp[c]); end
            checks++; if (master_req_o !== mexp[c]) begin failures++; $display("FAIL full_mreq c=%0d got=%b exp=%b", c, master_req_o, mexp[c]); end
            checks++; if (r_valid_o !== ((c == 4) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL full_rv c=%0d got=%b", c, r_valid_o); end
            cyc();
        end
        req_i = 2'b00; master_gnt_i = 1'b0; master_r_valid_i = 1'b1;
        #2;
        checks++; if (r_valid_o !== 2'b01) begin failures++; $display("FAIL full_drain0 got=%b exp=01", r_valid_o); end
        cyc();
        #2;
        checks++; if (r_valid_o !== 2'b10) begin failures++; $display("FAIL full_drain1 got=%b exp=10", r_valid_o); end
        cyc();
        master_r_valid_i = 1'b0;
    endtask

    task automatic test_unexpected();
        master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEAD;
        #2;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL unexp_err got=%b exp=1", err_o); end
        checks++; if (r_valid_o !== 2'b00) begin failures++; $display("FAIL unexp_rv got=%b exp=00", r_valid_o); end
        cyc();
        master_r_valid_i = 1'b0;
        #2;
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL unexp_err_clear got=%b exp=0", err_o); end
        cyc();
    endtask

    task automatic test_reset_mid();
        req_i = 2'b10; master_gnt_i = 1'b1;
        #2;
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL rstmid_g0 got=%b exp=10", gnt_o); end
        cyc();
        req_i = 2'b11;
        #2;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL rstmid_g1 got=%b exp=01", gnt_o); end
        cyc();
        req_i = 2'b00; master_gnt_i = 1'b0; rst_n = 1'b0;
        #2;
        checks++; if (gnt_o !== 2'b00 || r_valid_o !== 2'b00 || master_req_o !== 1'b0) begin
            failures++; $display("FAIL rstmid_in_reset gnt=%b rv=%b mreq=%b exp=00/00/0", gnt_o, r_valid_o, master_req_o);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        master_r_valid_i = 1'b1; master_r_rdata_i = 32'h55;
        #2;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL rstmid_err got=%b exp=1", err_o); end
        checks++; if (r_valid_o !== 2'b00) begin failures++; $display("FAIL rstmid_rv got=%b exp=00", r_valid_o); end
        cyc();
        master_r_valid_i = 1'b0; req_i = 2'b11; master_gnt_i = 1'b1;
        #2;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL rstmid_first_gnt got=%b exp=01", gnt_o); end
        cyc();
        req_i = 2'b00; master_gnt_i = 1'b0; master_r_valid_i = 1'b1;
        #2;
        checks++; if (r_valid_o !== 2'b01) begin failures++; $display("FAIL rstmid_drain got=%b exp=01", r_valid_o); end
        cyc();
        master_r_valid_i = 1'b0;
    endtask

`ifdef DM_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] rq   [0:6];
        logic [1:0] lk   [0:6];
        logic       rv   [0:6];
        logic [1:0] gexp [0:6];
        logic [1:0] rexp [0:6];
        rq   = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00};
        lk   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        rv   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        gexp = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
        rexp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10};
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        master_gnt_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_i = rq[c]; lock_i = lk[c]; master_r_valid_i = rv[c];
            #2;
            checks++; if (gnt_o !== gexp[c]) begin failures++; $display("FAIL lock_gnt c=%0d got=%b exp=%b", c, gnt_o, gexp[c]); end
            checks++; if (r_valid_o !== rexp[c]) begin failures++; $display("FAIL lock_rv c=%0d got=%b exp=%b", c, r_valid_o, rexp[c]); end
            cyc();
        end
        master_gnt_i = 1'b0; master_r_valid_i = 1'b0; req_i = '0; lock_i = '0;
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_round_robin();
        test_hold();
        test_full();
        test_unexpected();
        test_reset_mid();
`ifdef DM_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
